// File: rtl/ocm_noise_fetch.sv
// ocm_noise_fetch: read-side sequencer for the on-chip noise memory.
// Issues word reads on the memory's second port, buffers up to two words and
// unpacks each word into SAMPLE_W-wide samples (lane 0 first) on a
// valid/ready stream. Supports one-shot and looped playback.
// Optional build macro NOISE_FETCH_STATS_EN adds the underflow_cnt output.
//
// state   | meaning
// S_IDLE  | waiting for a legal cfg_start
// S_RUN   | issuing reads base..base+len-1 (wrapping when looping)
// S_DRAIN | all words issued, streaming out what is left in the buffer
module ocm_noise_fetch #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 64,
  parameter int SAMPLE_W = 16,
  parameter int DEPTH    = 8960
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic [ADDR_W-1:0]     cfg_base,
  input  logic [ADDR_W-1:0]     cfg_len,
  input  logic                  cfg_loop,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic [ADDR_W-1:0]     mem_address,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata,
  output logic [SAMPLE_W-1:0]   sample_data,
  output logic                  sample_valid,
  input  logic                  sample_ready
`ifdef NOISE_FETCH_STATS_EN
  ,
  output logic [31:0]           underflow_cnt
`endif
);

  localparam int LANES  = DATA_W / SAMPLE_W;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W-1:0]   r_len;
  logic                r_loop;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_issue_idx;
  logic                r_inflight;
  logic [DATA_W-1:0]   r_fifo [2];
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [1:0]          r_fifo_cnt;
  logic [LANE_W-1:0]   r_lane;
  logic                r_cfg_err;

  logic [ADDR_W:0]     w_end;
  logic                w_cfg_bad;
  logic                w_start_ok;
  logic                w_start_bad;
  logic                w_issue;
  logic                w_wrap;
  logic                w_valid;
  logic                w_accept;
  logic                w_pop;
  logic                w_push;
  logic                w_done;
  logic [DATA_W-1:0]   w_head;
  logic [SAMPLE_W-1:0] w_lanes [LANES];

  // End address is formed one bit wider so base+len cannot wrap past DEPTH.
  assign w_end       = {1'b0, cfg_base} + {1'b0, cfg_len};
  assign w_cfg_bad   = (cfg_len == '0) || (w_end > DEPTH_L);
  assign w_start_ok  = (r_state == S_IDLE) && cfg_start && !cfg_stop && !w_cfg_bad;
  assign w_start_bad = (r_state == S_IDLE) && cfg_start && !cfg_stop && w_cfg_bad;

  // A read is only issued when the buffer can absorb it, counting the one in flight.
  assign w_issue  = (r_state == S_RUN) && !cfg_stop
                    && ((r_fifo_cnt + {1'b0, r_inflight}) < 2'd2);
  assign w_wrap   = (r_issue_idx == (r_len - ADDR_W'(1)));
  assign w_valid  = (r_fifo_cnt != 2'd0);
  assign w_accept = w_valid && sample_ready;
  assign w_pop    = w_accept && (r_lane == LANE_W'(LANES-1));
  assign w_push   = r_inflight;
  assign w_done   = (r_state == S_DRAIN) && !cfg_stop && w_pop
                    && (r_fifo_cnt == 2'd1) && !r_inflight;

  assign w_head = r_fifo[r_rd_ptr];
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_lanes[g] = w_head[g*SAMPLE_W +: SAMPLE_W];
  end

  assign busy           = (r_state != S_IDLE);
  assign done           = w_done;
  assign cfg_err        = r_cfg_err;
  assign mem_address    = r_addr;
  assign mem_chipselect = w_issue;
  assign mem_write      = 1'b0;
  assign mem_byteenable = '1;
  assign mem_clken      = 1'b1;
  assign sample_valid   = w_valid;
  assign sample_data    = w_valid ? w_lanes[r_lane] : '0;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; stop overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_nxt = S_RUN;
      S_RUN:   if (w_issue && w_wrap && !r_loop) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (cfg_stop) w_state_nxt = S_IDLE;
  end

  // Configuration latch and read address sequencing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base      <= '0;
      r_len       <= '0;
      r_loop      <= 1'b0;
      r_addr      <= '0;
      r_issue_idx <= '0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_err <= w_start_bad;
      if (w_start_ok) begin
        r_base      <= cfg_base;
        r_len       <= cfg_len;
        r_loop      <= cfg_loop;
        r_addr      <= cfg_base;
        r_issue_idx <= '0;
      end else if (w_issue) begin
        if (w_wrap) begin
          r_addr      <= r_base;
          r_issue_idx <= '0;
        end else begin
          r_addr      <= r_addr + ADDR_W'(1);
          r_issue_idx <= r_issue_idx + ADDR_W'(1);
        end
      end
    end
  end

  // Word buffer, in-flight tracking and lane unpacking; stop discards everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inflight <= 1'b0;
      r_fifo[0]  <= '0;
      r_fifo[1]  <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_fifo_cnt <= 2'd0;
      r_lane     <= '0;
    end else if (cfg_stop) begin
      r_inflight <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_fifo_cnt <= 2'd0;
      r_lane     <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_push) begin
        r_fifo[r_wr_ptr] <= mem_readdata;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
        r_lane   <= '0;
      end else if (w_accept) begin
        r_lane <= r_lane + LANE_W'(1);
      end
      r_fifo_cnt <= r_fifo_cnt + 2'(w_push) - 2'(w_pop);
    end
  end

`ifdef NOISE_FETCH_STATS_EN
  logic [31:0] r_underflow;

  // Counts RUN cycles where the consumer is waiting on an empty stream; saturates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_underflow <= '0;
    end else if (w_start_ok) begin
      r_underflow <= '0;
    end else if ((r_state == S_RUN) && !w_valid && sample_ready && (r_underflow != '1)) begin
      r_underflow <= r_underflow + 32'd1;
    end
  end

  assign underflow_cnt = r_underflow;
`endif

endmodule

// File: tb/tb_ocm_noise_fetch.sv
// Bench for ocm_noise_fetch: table of playback runs, random runs, and
// hand-written stop / reset / start-while-busy sequences, checked against a
// sample-index model of the expected stream.
module tb_ocm_noise_fetch;

  localparam int DEPTH = 8960;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_start, cfg_stop, cfg_loop;
  logic [13:0] cfg_base, cfg_len;
  logic        busy, done, cfg_err;
  logic [13:0] mem_address;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [7:0]  mem_byteenable;
  logic [63:0] mem_readdata;
  logic [15:0] sample_data;
  logic        sample_valid, sample_ready;
`ifdef NOISE_FETCH_STATS_EN
  logic [31:0] underflow_cnt;
`endif

  ocm_noise_fetch dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_base(cfg_base),
    .cfg_len(cfg_len), .cfg_loop(cfg_loop),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_byteenable(mem_byteenable), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready)
`ifdef NOISE_FETCH_STATS_EN
    , .underflow_cnt(underflow_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Each lane encodes its own lane number and word address.
  function automatic logic [63:0] memw(input logic [13:0] a);
    logic [63:0] w;
    for (int k = 0; k < 4; k++) w[k*16 +: 16] = {2'(k), a} ^ 16'h5A5A;
    return w;
  endfunction

  // Memory model: data valid exactly one clock after the chipselect cycle, junk otherwise.
  always @(posedge clk)
    mem_readdata <= mem_chipselect ? memw(mem_address) : 64'hDEAD_BEEF_DEAD_BEEF;

  // Reference: n-th accepted sample of a run is lane n%4 of word base + (n/4) mod len.
  function automatic logic [15:0] exp_sample(input int base, input int len, input int n);
    int a;
    a = base + ((n / 4) % len);
    return {2'(n % 4), 14'(a)} ^ 16'h5A5A;
  endfunction

  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Stream monitor state.
  bit          mon_en = 0;
  int          cyc = 0;
  int          start_cyc, first_v, last_acc, n_acc, n_done, done_idx, n_errp, n_busy;
  int          max_out, hold_viol;
  bit          hold_pend, prev_stop;
  logic [15:0] hold_data;
  logic [15:0] q_samp[$];
  logic [13:0] q_addr[$];

  task automatic mon_clear();
    start_cyc = -1; first_v = -1; last_acc = -1; n_acc = 0; n_done = 0;
    done_idx = -1; n_errp = 0; n_busy = 0; max_out = 0; hold_viol = 0;
    hold_pend = 0; prev_stop = 0;
    q_samp.delete();
    q_addr.delete();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      int outst;
      if (cfg_start && start_cyc < 0) start_cyc = cyc;
      if (sample_valid && first_v < 0) first_v = cyc;
      if (mem_chipselect) q_addr.push_back(mem_address);
      outst = q_addr.size() - n_acc / 4;
      if (outst > max_out) max_out = outst;
      if (hold_pend && !prev_stop && (!sample_valid || sample_data != hold_data)) hold_viol++;
      hold_pend = sample_valid && !sample_ready;
      hold_data = sample_data;
      prev_stop = cfg_stop;
      if (sample_valid && sample_ready) begin
        q_samp.push_back(sample_data);
        n_acc++;
        last_acc = cyc;
      end
      if (done) begin
        n_done++;
        done_idx = q_samp.size();
      end
      if (cfg_err) n_errp++;
      if (busy) n_busy++;
    end
    cyc++;
  end

  typedef struct {
    int base;
    int len;
    bit loop;
    int mode;      // 0 ready=1, 1 ready toggling, 2 random ready
    int nsamp;     // samples to collect before stopping a looped run
    bit poke;      // fire a second start while busy
    bit exp_err;   // start must be rejected
  } vec_t;

  function automatic logic rdy(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c % 2) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_case(input vec_t v, input string tag);
    int bound;
    bit to;
    mon_clear();
    mon_en = 1;
    @(posedge clk); #1;
    cfg_base = 14'(v.base); cfg_len = 14'(v.len); cfg_loop = v.loop;
    cfg_start = 1'b1; sample_ready = rdy(v.mode, 0);
    if (v.exp_err) begin
      @(posedge clk); #1;
      cfg_start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      mon_en = 0;
      check({tag, " cfg_err_pulses"}, n_errp, 1);
      check({tag, " busy_cycles"}, n_busy, 0);
      check({tag, " reads"}, q_addr.size(), 0);
    end else begin
      bound = 100 + 12 * (v.loop ? v.nsamp : 4 * v.len);
      to = 1;
      for (int c = 1; c < bound; c++) begin
        @(posedge clk); #1;
        if (v.poke && c == 5) begin
          cfg_start = 1'b1; cfg_base = 14'd777; cfg_len = 14'd1; cfg_loop = 1'b1;
        end else begin
          cfg_start = 1'b0;
        end
        if (!v.loop && n_done > 0) begin to = 0; break; end
        if (v.loop && q_samp.size() >= v.nsamp) begin to = 0; break; end
        sample_ready = rdy(v.mode, c);
      end
      cfg_start = 1'b0;
      check({tag, " timeout"}, to, 0);
      if (v.loop) begin
        sample_ready = 1'b0; cfg_stop = 1'b1;
        @(posedge clk); #1;
        cfg_stop = 1'b0;
        @(negedge clk);
        check({tag, " valid_after_stop"}, sample_valid, 0);
        check({tag, " busy_after_stop"}, busy, 0);
        check({tag, " enough_samples"}, q_samp.size() >= v.nsamp, 1);
        check({tag, " done_count"}, n_done, 0);
      end else begin
        check({tag, " busy_after_done"}, busy, 0);
        check({tag, " sample_count"}, q_samp.size(), 4 * v.len);
        check({tag, " done_count"}, n_done, 1);
        check({tag, " done_with_last"}, done_idx, 4 * v.len);
        check({tag, " read_count"}, q_addr.size(), v.len);
      end
      mon_en = 0;
      for (int i = 0; i < q_samp.size(); i++)
        check($sformatf("%s sample[%0d]", tag, i), q_samp[i], exp_sample(v.base, v.len, i));
      for (int i = 0; i < q_addr.size(); i++)
        check($sformatf("%s addr[%0d]", tag, i), q_addr[i], v.base + (i % v.len));
      check({tag, " first_valid_latency"}, first_v - start_cyc, 3);
      if (v.mode == 0)
        check({tag, " continuous"}, last_acc - first_v + 1, q_samp.size());
      check({tag, " outstanding_le2"}, max_out <= 2, 1);
      check({tag, " hold_stable"}, hold_viol, 0);
    end
    sample_ready = 1'b0;
    cfg_start = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " cfg_err"}, cfg_err, 0);
    check({tag, " chipselect"}, mem_chipselect, 0);
    check({tag, " address"}, mem_address, 0);
    check({tag, " valid"}, sample_valid, 0);
    check({tag, " data"}, sample_data, 0);
`ifdef NOISE_FETCH_STATS_EN
    check({tag, " underflow_cnt"}, underflow_cnt, 0);
`endif
  endtask

  vec_t tbl[11];

  initial begin
    vec_t rv;
    int   acc;

    tbl[0]  = '{base:0,     len:2,     loop:0, mode:0, nsamp:0,  poke:0, exp_err:0};
    tbl[1]  = '{base:8958,  len:2,     loop:1, mode:0, nsamp:20, poke:0, exp_err:0};
    tbl[2]  = '{base:8959,  len:2,     loop:0, mode:0, nsamp:0,  poke:0, exp_err:1};
    tbl[3]  = '{base:0,     len:4,     loop:0, mode:1, nsamp:0,  poke:0, exp_err:0};
    tbl[4]  = '{base:10,    len:0,     loop:0, mode:0, nsamp:0,  poke:0, exp_err:1};
    tbl[5]  = '{base:8950,  len:10,    loop:0, mode:2, nsamp:0,  poke:0, exp_err:0};
    tbl[6]  = '{base:8950,  len:11,    loop:0, mode:0, nsamp:0,  poke:0, exp_err:1};
    tbl[7]  = '{base:0,     len:3,     loop:0, mode:0, nsamp:0,  poke:1, exp_err:0};
    tbl[8]  = '{base:8959,  len:1,     loop:0, mode:1, nsamp:0,  poke:0, exp_err:0};
    tbl[9]  = '{base:5,     len:1,     loop:1, mode:2, nsamp:13, poke:0, exp_err:0};
    tbl[10] = '{base:16383, len:16383, loop:0, mode:0, nsamp:0,  poke:0, exp_err:1};

    reset_n = 1'b0; cfg_start = 0; cfg_stop = 0; cfg_loop = 0;
    cfg_base = '0; cfg_len = '0; sample_ready = 0;
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    check("reset mem_write", mem_write, 0);
    check("reset byteenable", mem_byteenable, 8'hFF);
    check("reset clken", mem_clken, 1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 11; i++) begin
      run_case(tbl[i], $sformatf("tbl%0d", i));
`ifdef NOISE_FETCH_STATS_EN
      if (i == 0) check("tbl0 underflow_cnt", underflow_cnt, 2);
`endif
    end

    // Stop while the first read is in flight, then restart elsewhere.
    @(posedge clk); #1;
    cfg_base = 14'd100; cfg_len = 14'd4; cfg_loop = 1'b0; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    @(posedge clk); #1;
    cfg_stop = 1'b1;
    @(posedge clk); #1;
    cfg_stop = 1'b0;
    @(negedge clk);
    check("stop_inflight valid", sample_valid, 0);
    check("stop_inflight busy", busy, 0);
    run_case('{base:200, len:2, loop:0, mode:0, nsamp:0, poke:0, exp_err:0}, "restart");

    // Start and stop in the same cycle: nothing must happen.
    @(posedge clk); #1;
    cfg_base = 14'd300; cfg_len = 14'd2; cfg_start = 1'b1; cfg_stop = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0; cfg_stop = 1'b0;
    acc = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy || mem_chipselect || cfg_err) acc++;
    end
    check("start_stop_same_clk activity", acc, 0);

    // Asynchronous reset in the middle of a looped run.
    @(posedge clk); #1;
    cfg_base = 14'd50; cfg_len = 14'd3; cfg_loop = 1'b1; cfg_start = 1'b1; sample_ready = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    check("midrun valid_before_reset", sample_valid, 1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset valid", sample_valid, 0);
    check("post_reset busy", busy, 0);
    sample_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Randomised runs; legality decided with plain integer arithmetic.
    for (int r = 0; r < 16; r++) begin
      int maxl;
      rv.base  = $urandom_range(0, DEPTH - 1);
      maxl     = (DEPTH - rv.base < 12) ? DEPTH - rv.base : 12;
      rv.len   = $urandom_range(1, maxl);
      if ($urandom_range(0, 5) == 0) rv.len = DEPTH - rv.base + 1 + $urandom_range(0, 3);
      rv.loop  = 1'($urandom_range(0, 1));
      rv.mode  = $urandom_range(0, 2);
      rv.nsamp = $urandom_range(4, 40);
      rv.poke  = 1'($urandom_range(0, 1));
      rv.exp_err = (rv.len == 0) || (rv.base + rv.len > DEPTH);
      run_case(rv, $sformatf("rnd%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
